// File: rtl/fifo_bist_pkg.sv
// Shared types and constants for the FIFO BIST write sequencer and the
// pattern generator it shares with the read-side checker.
package fifo_bist_pkg;

    localparam int NPAT = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_CHK_FULL,
        S_REQ_HI,
        S_REQ_LO,
        S_DONE
    } state_e;

    typedef enum logic [2:0] {
        PAT_ZERO = 3'd0,
        PAT_ONE  = 3'd1,
        PAT_CHK  = 3'd2,
        PAT_ICHK = 3'd3,
        PAT_ADDR = 3'd4
    } pat_e;

endpackage

// File: rtl/fifo_bist_pat_gen.sv
// Combinational BIST data pattern: (pattern id, word index) -> data word.
// The read-side checker instantiates the same block to form expected data.
module fifo_bist_pat_gen
    import fifo_bist_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = 4
) (
    input  logic [2:0]       pat_id,
    input  logic [IDX_W-1:0] idx,
    output logic [WIDTH-1:0] data
);

    logic [WIDTH-1:0] chk;
    logic [WIDTH-1:0] addr;

    // Checkerboard flips phase on every word so adjacent cells and words differ.
    assign chk = idx[0] ? {(WIDTH/2){2'b10}} : {(WIDTH/2){2'b01}};

    generate
        if (IDX_W >= WIDTH) begin : g_addr_trunc
            assign addr = idx[WIDTH-1:0];
        end else begin : g_addr_ext
            assign addr = {{(WIDTH-IDX_W){1'b0}}, idx};
        end
    endgenerate

    always_comb begin
        data = '0;
        case (pat_id)
            PAT_ZERO: data = '0;
            PAT_ONE:  data = '1;
            PAT_CHK:  data = chk;
            PAT_ICHK: data = ~chk;
            PAT_ADDR: data = addr;
            default:  data = '0;
        endcase
    end

endmodule

// File: rtl/fifo_bist_wr_ctrl.sv
// BIST write-side sequencer: fills the FIFO once per pattern, verifies the
// full flag timing, then hands each load to the read checker via REQ/ACK.
module fifo_bist_wr_ctrl
    import fifo_bist_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 10,
    parameter int FULL_TO = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             W_FULL,
    input  logic             PASS_ACK,
    output logic             W_INC,
    output logic [WIDTH-1:0] W_DATA,
    output logic             PASS_REQ,
    output logic [2:0]       PAT_ID,
    output logic             BUSY,
    output logic             DONE,
    output logic             OVF_ERR,
    output logic             FULL_ERR
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(FULL_TO + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(FULL_TO - 1);
    localparam logic [2:0]    PAT_LAST = 3'(NPAT - 1);

    state_e        state, state_nx;
    logic [CW-1:0] wr_cnt, wr_cnt_nx;
    logic [TW-1:0] tmo, tmo_nx;
    logic [2:0]    pat, pat_nx;
    logic          ovf, ovf_nx;
    logic          ferr, ferr_nx;
    logic          wr;

    // Strobe is combinational so a write can never coincide with W_FULL.
    assign wr = (state == S_WRITE) && !W_FULL && !RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= S_IDLE;
            wr_cnt <= '0;
            tmo    <= '0;
            pat    <= '0;
            ovf    <= 1'b0;
            ferr   <= 1'b0;
        end else begin
            state  <= state_nx;
            wr_cnt <= wr_cnt_nx;
            tmo    <= tmo_nx;
            pat    <= pat_nx;
            ovf    <= ovf_nx;
            ferr   <= ferr_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        wr_cnt_nx = wr_cnt;
        tmo_nx    = tmo;
        pat_nx    = pat;
        ovf_nx    = ovf;
        ferr_nx   = ferr;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (START) begin
                    state_nx  = S_WRITE;
                    wr_cnt_nx = '0;
                    tmo_nx    = '0;
                    pat_nx    = '0;
                    ovf_nx    = 1'b0;
                    ferr_nx   = 1'b0;
                end
            end
            S_WRITE: begin
                if (W_FULL) begin
                    // Early full: flag it, but still hand off the partial load.
                    ovf_nx   = 1'b1;
                    state_nx = S_REQ_HI;
                end else begin
                    wr_cnt_nx = wr_cnt + 1'b1;
                    if (wr_cnt == LAST_IDX) begin
                        state_nx = S_CHK_FULL;
                        tmo_nx   = '0;
                    end
                end
            end
            S_CHK_FULL: begin
                if (W_FULL) begin
                    state_nx = S_REQ_HI;
                end else if (tmo == TMO_LAST) begin
                    ferr_nx  = 1'b1;
                    state_nx = S_REQ_HI;
                end else begin
                    tmo_nx = tmo + 1'b1;
                end
            end
            S_REQ_HI: begin
                if (PASS_ACK) state_nx = S_REQ_LO;
            end
            S_REQ_LO: begin
                if (!PASS_ACK) begin
                    if (pat == PAT_LAST) begin
                        state_nx = S_DONE;
                    end else begin
                        pat_nx    = pat + 1'b1;
                        wr_cnt_nx = '0;
                        state_nx  = S_WRITE;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    fifo_bist_pat_gen #(
        .WIDTH (WIDTH),
        .IDX_W (CW)
    ) u_pat_gen (
        .pat_id (pat),
        .idx    (wr_cnt),
        .data   (W_DATA)
    );

    assign W_INC    = wr;
    assign PASS_REQ = (state == S_REQ_HI);
    assign BUSY     = (state != S_IDLE) && (state != S_DONE);
    assign DONE     = (state == S_DONE);
    assign PAT_ID   = pat;
    assign OVF_ERR  = ovf;
    assign FULL_ERR = ferr;

endmodule

// File: tb/tb_fifo_bist_wr_ctrl.sv
// Bench for fifo_bist_wr_ctrl: behavioural FIFO-full / read-checker environment
// plus an arithmetic model of write stream, error flags and run length.
module tb_fifo_bist_wr_ctrl;

    localparam int WIDTH = 8, DEPTH = 10, FULL_TO = 4, NP = 5, NEVER = 255;

    logic CLK = 1'b0;
    logic RST, START, W_FULL, PASS_ACK;
    logic W_INC, PASS_REQ, BUSY, DONE, OVF_ERR, FULL_ERR;
    logic [WIDTH-1:0] W_DATA;
    logic [2:0] PAT_ID;

    fifo_bist_wr_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FULL_TO(FULL_TO)) dut (
        .CLK(CLK), .RST(RST), .START(START), .W_FULL(W_FULL), .PASS_ACK(PASS_ACK),
        .W_INC(W_INC), .W_DATA(W_DATA), .PASS_REQ(PASS_REQ), .PAT_ID(PAT_ID),
        .BUSY(BUSY), .DONE(DONE), .OVF_ERR(OVF_ERR), .FULL_ERR(FULL_ERR)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0, n_bad = 0;

    // environment knobs
    int thr[NP], lat[NP];
    int ack_dly, ack_lo, tog_load, tog_at;
    bit noise, start_drv;
    // environment state
    int fcnt, dcnt, atimer, lp;
    bit full_q, ack, tog_on, tog_ph;
    // observations
    int cyc, done_cyc, full_wr_viol, ferr_first, ovf_first, tog_first;
    int nwr[NP], fw[NP], lw[NP];
    logic [WIDTH-1:0] got[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] pat(input int p, input int i);
        logic [WIDTH-1:0] cb;
        for (int b = 0; b < WIDTH; b++) cb[b] = ((b % 2) == 0) ^ ((i % 2) == 1);
        case (p)
            0: return '0;
            1: return '1;
            2: return cb;
            3: return ~cb;
            default: return WIDTH'(i);
        endcase
    endfunction

    task automatic cfg_default();
        for (int p = 0; p < NP; p++) begin thr[p] = DEPTH; lat[p] = 0; end
        ack_dly = 1; ack_lo = 0; tog_load = -1; tog_at = 3; noise = 0;
    endtask

    task automatic env_obs_clear();
        fcnt = 0; dcnt = 0; atimer = 0; lp = 0;
        full_q = 0; ack = 0; tog_on = 0; tog_ph = 0;
        cyc = 0; done_cyc = -1; full_wr_viol = 0;
        ferr_first = -1; ovf_first = -1; tog_first = -1;
        for (int p = 0; p < NP; p++) begin nwr[p] = 0; fw[p] = 0; lw[p] = 0; end
        got.delete();
    endtask

    // One cycle: drive at negedge, sample 1ns later, then advance the model
    // of the FIFO full flag and the read checker as the next posedge will.
    task automatic tick();
        @(negedge CLK);
        START    = start_drv | (noise && cyc > 0 && lp < NP-1 && $urandom_range(0, 3) == 0);
        PASS_ACK = ack;
        W_FULL   = tog_on ? tog_ph : full_q;
        #1;
        if (W_FULL && W_INC) full_wr_viol++;
        if (W_FULL && tog_on && tog_first < 0) tog_first = cyc;
        if (FULL_ERR && ferr_first < 0) ferr_first = cyc;
        if (OVF_ERR && ovf_first < 0) ovf_first = cyc;
        if (DONE && cyc > 0 && done_cyc < 0) done_cyc = cyc;
        if (W_INC) begin
            got.push_back(W_DATA);
            if (lp < NP) begin
                if (nwr[lp] == 0) fw[lp] = cyc;
                lw[lp] = cyc;
                nwr[lp]++;
            end
            fcnt++;
        end
        if (lp < NP && fcnt >= thr[lp] && !full_q) begin
            if (dcnt == lat[lp]) full_q = 1; else dcnt++;
        end
        if (tog_on) tog_ph = !tog_ph;
        else if (lp == tog_load && fcnt >= tog_at) begin tog_on = 1; tog_ph = 1; end
        if (PASS_REQ && !ack) begin
            if (atimer == ack_dly) begin ack = 1; atimer = 0; end else atimer++;
        end else if (!PASS_REQ && ack) begin
            if (atimer == ack_lo) begin
                ack = 0; atimer = 0; fcnt = 0; dcnt = 0; full_q = 0; tog_on = 0; lp++;
            end else atimer++;
        end
        cyc++;
    endtask

    task automatic run(input string nm);
        logic [WIDTH-1:0] expq[$];
        int exp_cyc, smis, gaps;
        bit e_ovf, e_ferr;
        exp_cyc = 1; e_ovf = 0; e_ferr = 0;
        for (int p = 0; p < NP; p++) begin
            int n;
            bit o;
            if (tog_load == p) begin n = tog_at; o = 1; end
            else if (thr[p] + lat[p] < DEPTH) begin n = thr[p] + lat[p]; o = 1; end
            else begin n = DEPTH; o = 0; end
            exp_cyc += o ? n + 1 : n;
            if (o) e_ovf = 1;
            else if (thr[p] <= DEPTH && thr[p] + lat[p] - DEPTH < FULL_TO)
                exp_cyc += thr[p] + lat[p] - DEPTH + 1;
            else begin exp_cyc += FULL_TO; e_ferr = 1; end
            exp_cyc += (ack_dly + 2) + (ack_lo + 2);
            for (int i = 0; i < n; i++) expq.push_back(pat(p, i));
        end

        env_obs_clear();
        start_drv = 1; tick(); start_drv = 0;
        while (done_cyc < 0 && cyc < 3000) tick();

        smis = 0;
        for (int i = 0; i < expq.size() && i < got.size(); i++)
            if (got[i] !== expq[i]) smis++;
        gaps = 0;
        for (int p = 0; p < NP; p++)
            if (nwr[p] > 0 && lw[p] - fw[p] + 1 != nwr[p]) gaps++;

        chk({nm, ".done_seen"}, done_cyc >= 0, 1);
        chk({nm, ".run_cycles"}, done_cyc, exp_cyc);
        chk({nm, ".done"}, DONE, 1);
        chk({nm, ".busy"}, BUSY, 0);
        chk({nm, ".pat_id"}, PAT_ID, 4);
        chk({nm, ".ovf_err"}, OVF_ERR, e_ovf);
        chk({nm, ".full_err"}, FULL_ERR, e_ferr);
        chk({nm, ".n_writes"}, got.size(), expq.size());
        chk({nm, ".data_mism"}, smis, 0);
        chk({nm, ".gaps"}, gaps, 0);
        chk({nm, ".first_wr"}, fw[0], 1);
        chk({nm, ".wr_when_full"}, full_wr_viol, 0);
    endtask

    initial begin
        RST = 1; START = 0; W_FULL = 0; PASS_ACK = 0; start_drv = 0;
        cfg_default(); env_obs_clear();
        repeat (3) @(negedge CLK);
        #1;
        chk("reset_outs", {W_INC, W_DATA, PASS_REQ, PAT_ID, BUSY, DONE, OVF_ERR, FULL_ERR}, 0);
        RST = 0;

        // nominal run
        cfg_default();
        run("nominal");
        chk("nominal.total", got.size(), 50);
        chk("nominal.p2_w0", got[20], 8'h55);
        chk("nominal.p2_w1", got[21], 8'hAA);
        chk("nominal.p2_w2", got[22], 8'h55);
        chk("nominal.p4_w0", got[40], 8'h00);
        chk("nominal.p4_w9", got[49], 8'h09);

        // reset in the middle of a load (pattern 4, after 5 writes)
        cfg_default(); env_obs_clear();
        start_drv = 1; tick(); start_drv = 0;
        while (!(lp == 4 && nwr[4] == 5) && cyc < 3000) tick();
        chk("midrst.reached", nwr[4], 5);
        @(negedge CLK);
        RST = 1; START = 0; W_FULL = 0; PASS_ACK = 0;
        #1;
        chk("midrst.winc_in_rst", W_INC, 0);
        @(negedge CLK);
        #1;
        chk("midrst.outs", {W_INC, W_DATA, PASS_REQ, PAT_ID, BUSY, DONE, OVF_ERR, FULL_ERR}, 0);
        RST = 0;
        run("after_rst");

        // early full on pattern 1 after 7 writes
        cfg_default(); thr[1] = 7;
        run("ovf_p1");
        chk("ovf_p1.p1_writes", nwr[1], 7);

        // full never arrives on pattern 0
        cfg_default(); thr[0] = NEVER;
        run("nofull_p0");
        chk("nofull_p0.ferr_lat", ferr_first - lw[0], FULL_TO + 1);

        // long ACK high phase, START noise while busy
        cfg_default(); ack_lo = 5; noise = 1;
        run("ack_hold");

        // W_FULL toggling from the 4th write slot of pattern 0
        cfg_default(); thr[0] = NEVER; tog_load = 0; tog_at = 3;
        run("toggle");
        chk("toggle.ovf_lat", ovf_first - tog_first, 1);
        chk("toggle.p0_writes", nwr[0], 3);

        // randomized environment timing
        for (int r = 0; r < 8; r++) begin
            cfg_default();
            ack_dly = $urandom_range(0, 3);
            ack_lo  = $urandom_range(0, 3);
            noise   = $urandom_range(0, 1);
            for (int p = 0; p < NP; p++) begin
                thr[p] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DEPTH-1)) : DEPTH;
                lat[p] = $urandom_range(0, FULL_TO + 1);
            end
            run($sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
